instr_mem_sync: RTL
===================

Name: instr_mem_sync

Overview:
Parametrised, clocked instruction memory for the fetch stage; successor to the combinational lookup ROM.
- Adds a request/response handshake, configurable wait-state latency, byte or word addressing, and an out-of-range flag.
- Adds a synchronous load port so test benches and the boot loader can write the program at run time.
- Sits between the PC/fetch logic and the IF/ID pipeline register.

Parameters:
DATA_W, 32, instruction word width in bits
DEPTH, 128, number of words in the array
ADDR_W, 32, width of the request and write addresses
WAIT_STATES, 0, extra cycles between request acceptance and the response (0..15)
BYTE_ADDR, 1, 1 = addresses are byte addresses (index = addr >> 2); 0 = word addresses

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  fetch request present
req_ready  out  1  block can accept a request this cycle
req_addr  in  ADDR_W  fetch address
rsp_valid  out  1  response data valid
rsp_ready  in  1  consumer accepts the response
rsp_data  out  DATA_W  fetched instruction
rsp_oob  out  1  response came from an address with index >= DEPTH
wr_en  in  1  load-port write strobe
wr_addr  in  ADDR_W  load address; same addressing mode as req_addr
wr_data  in  DATA_W  load data

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state = IDLE, rsp_valid = 0, rsp_data = 0, rsp_oob = 0, wait counter = 0. The memory array is not cleared by reset.
- Reset mid-operation: any in-flight transaction is dropped and no response is produced.
- FSM states are IDLE, WAIT and RESP.
- req_ready = (state == IDLE) || (state == RESP && rsp_ready).
- Accept occurs when req_valid && req_ready; on accept, the index is latched.
  - WAIT_STATES == 0: go to RESP on the next edge.
  - Otherwise: go to WAIT and load the counter with WAIT_STATES. Decrement the counter each cycle; when it reaches 1, go to RESP on the next edge.
- Latency: rsp_valid rises exactly WAIT_STATES + 1 cycles after the accept edge.
- Data capture: rsp_data and rsp_oob are registered on the edge that enters RESP.
- In RESP: rsp_valid = 1, and rsp_data and rsp_oob are held stable until rsp_ready.
- On response handshake:
  - With a simultaneous accept: go back-to-back to WAIT or RESP. With WAIT_STATES = 0 this gives full throughput.
  - Without a simultaneous accept: go to IDLE and drop rsp_valid next cycle.
- Out of range: when the index is >= DEPTH, rsp_data = 0 and rsp_oob = 1, and the array is not read.
- Byte addressing: with BYTE_ADDR = 1, addr[1:0] is ignored and the index is taken from addr[...:2].
- Load port:
  - A write with wr_en occurs at the rising edge, in any state.
  - An out-of-range wr_addr is ignored silently.
  - Read-before-write: a write on the same edge that captures data into rsp_data returns the old word. A write on any earlier edge is visible.
- Requests arriving while req_ready = 0 are not accepted. The requester must hold req_valid and req_addr stable until accepted.

Optional Feature:
Macro: IMEM_ALIGN_CHECK_EN
- Defined: adds an output port rsp_misalign (1 bit, reset 0).
  - When BYTE_ADDR = 1 and the accepted req_addr[1:0] != 0, the response returns rsp_data = 0 and rsp_misalign = 1.
  - The response uses the normal latency and handshake.
  - Misalignment takes priority over out-of-range.
- Not defined: the port is absent and the low address bits are ignored.

Decomposition:
- Package imem_pkg:
  - state enum (IDLE, WAIT, RESP)
  - WAIT counter width constant (4)
  - word-index helper function (byte/word addressing)
- Sub-module imem_array: DEPTH x DATA_W storage with a synchronous write, an asynchronous read, and an in-range check.
- The top level holds the FSM, counter, handshake and output registers.

Test Plan:
- WAIT_STATES = 0, preload word 3 = 0x8C123456, request addr 0x0C, rsp_ready = 1 -> rsp_valid the next cycle with data 0x8C123456 and rsp_oob = 0; back-to-back requests 0x00, 0x04, 0x08 give one response per cycle.
- WAIT_STATES = 3, request addr 0x04 -> rsp_valid exactly 4 cycles after accept; req_ready = 0 throughout WAIT.
- Hold rsp_ready = 0 for 5 cycles in RESP -> rsp_data and rsp_valid stay stable and req_ready stays 0; releasing rsp_ready completes the handshake.
- Request addr 0x200 (index 128) -> rsp_data = 0, rsp_oob = 1; wr_en to index 200 leaves the array unchanged.
- Write 0xAD654321 to index 5 on the capture edge of a read of index 5 -> the read returns the old word; a second read returns 0xAD654321.
- Assert rst during WAIT -> the next cycle gives IDLE, rsp_valid = 0 and no response; with IMEM_ALIGN_CHECK_EN defined, addr 0x06 gives rsp_misalign = 1 and rsp_data = 0.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: shared types, constants and index helper for the clocked instruction memory
package imem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    localparam int CNT_W = 4;
    // Byte addresses drop the two low bits; word addresses are used as-is.
    function automatic logic [63:0] word_index(input logic [63:0] addr, input logic byte_addr);
        return byte_addr ? (addr >> 2) : addr;
    endfunction
endpackage

// File: rtl/imem_array.sv
// imem_array: DEPTH x DATA_W storage, synchronous write, asynchronous read, range checks
//   clk        clock
//   wr_en_i    write strobe; dropped silently when wr_idx_i is out of range
//   wr_idx_i   write word index
//   wr_data_i  write data
//   rd_idx_i   read word index
//   rd_data_o  read data, zero when out of range
//   rd_inr_o   read index is below DEPTH
module imem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_idx_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_idx_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_inr_o
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_inr;
    assign wr_inr    = wr_idx_i < ADDR_W'(DEPTH);
    assign rd_inr_o  = rd_idx_i < ADDR_W'(DEPTH);
    assign rd_data_o = rd_inr_o ? mem_q[rd_idx_i[IW-1:0]] : '0;
    always_ff @(posedge clk) begin
        if (wr_en_i && wr_inr) mem_q[wr_idx_i[IW-1:0]] <= wr_data_i;
    end
endmodule

// File: rtl/instr_mem_sync.sv
// instr_mem_sync: clocked instruction memory with req/rsp handshake, wait states and load port
//   clk, rst                   clock, synchronous active-high reset
//   req_valid/req_ready/req_addr   fetch request channel
//   rsp_valid/rsp_ready/rsp_data   fetch response channel
//   rsp_oob                    response came from an index >= DEPTH
//   rsp_misalign               only with IMEM_ALIGN_CHECK_EN: byte address had nonzero low bits
//   wr_en/wr_addr/wr_data      program load port
module instr_mem_sync
    import imem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 128,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 0,
    parameter int BYTE_ADDR   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_oob,
`ifdef IMEM_ALIGN_CHECK_EN
    output logic              rsp_misalign,
`endif
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);
    state_e            state_q, state_d, start_st;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, req_idx, wr_idx, rd_idx;
    logic [DATA_W-1:0] rsp_data_q, rd_data;
    logic              rsp_oob_q, rd_inr, accept, capture, cap_mis;

    assign req_idx   = ADDR_W'(word_index(64'(req_addr), BYTE_ADDR != 0));
    assign wr_idx    = ADDR_W'(word_index(64'(wr_addr), BYTE_ADDR != 0));
    assign req_ready = (state_q == IDLE) || (state_q == RESP && rsp_ready);
    assign accept    = req_valid && req_ready;
    assign start_st  = (WAIT_STATES == 0) ? RESP : WAIT;
    // Without wait states the capture happens on the accept edge, so read straight from the request.
    assign rd_idx    = (state_q == WAIT) ? idx_q : req_idx;
    assign capture   = (state_q == WAIT && cnt_q == CNT_W'(1)) || (accept && WAIT_STATES == 0);
    assign cnt_d     = accept ? CNT_W'(WAIT_STATES) : (state_q == WAIT) ? cnt_q - CNT_W'(1) : cnt_q;
    assign rsp_valid = state_q == RESP;
    assign rsp_data  = rsp_data_q;
    assign rsp_oob   = rsp_oob_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = start_st;
            WAIT:    if (cnt_q == CNT_W'(1)) state_d = RESP;
            RESP:    if (rsp_ready) state_d = accept ? start_st : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            rsp_data_q <= '0;
            rsp_oob_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) idx_q <= req_idx;
            if (capture) begin
                rsp_data_q <= cap_mis ? '0 : rd_data;
                rsp_oob_q  <= !cap_mis && !rd_inr;
            end
        end
    end

`ifdef IMEM_ALIGN_CHECK_EN
    logic mis_q, rsp_mis_q, req_mis;
    assign req_mis      = (BYTE_ADDR != 0) && (req_addr[1:0] != 2'b00);
    assign cap_mis      = (state_q == WAIT) ? mis_q : req_mis;
    assign rsp_misalign = rsp_mis_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            mis_q     <= 1'b0;
            rsp_mis_q <= 1'b0;
        end else begin
            if (accept) mis_q <= req_mis;
            if (capture) rsp_mis_q <= cap_mis;
        end
    end
`else
    assign cap_mis = 1'b0;
`endif

    imem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_array (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_idx_i  (wr_idx),
        .wr_data_i (wr_data),
        .rd_idx_i  (rd_idx),
        .rd_data_o (rd_data),
        .rd_inr_o  (rd_inr)
    );
endmodule
